// File: rtl/reflet_float_mult_arbiter_if.sv
// Requester and multiplier signals around the shared float multiplier.
// master is the arbiter's view; slave is the requester/multiplier side.
interface reflet_float_mult_arbiter_if #(
    parameter int n_req = 2
);
    logic [n_req-1:0]       req_valid;
    logic [n_req-1:0][31:0] req_in1;
    logic [n_req-1:0][31:0] req_in2;
    logic [n_req-1:0]       req_done;
    logic [31:0]            result;
    logic                   busy;
    logic                   mult_enable;
    logic [31:0]            mult_in1;
    logic [31:0]            mult_in2;
    logic                   mult_ready;
    logic [31:0]            mult_result;

    modport master (
        input  req_valid, req_in1, req_in2, mult_ready, mult_result,
        output req_done, result, busy, mult_enable, mult_in1, mult_in2
    );

    modport slave (
        output req_valid, req_in1, req_in2, mult_ready, mult_result,
        input  req_done, result, busy, mult_enable, mult_in1, mult_in2
    );
endinterface

// File: rtl/reflet_float_mult_arbiter.sv
// Round-robin arbiter sharing one float multiplier between n_req requesters.
// IDLE grants and latches operands, RUN waits for ready, CLEAR drops enable.
module reflet_float_mult_arbiter #(
    parameter int n_req = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    reflet_float_mult_arbiter_if.master  bus
);
    localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1;

    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    state_t             state, state_nx;
    logic [idx_w-1:0]   grant, grant_nx;
    logic [idx_w-1:0]   last_grant, last_nx;
    logic [n_req-1:0]   done_nx;
    logic [31:0]        result_nx, in1_nx, in2_nx;
    logic               en_nx, busy_nx;

    logic [idx_w-1:0]   pick, cand_idx;
    logic               pick_found;
    int                 cand;

    // Walk offsets from farthest to nearest so the nearest pending requester
    // after last_grant is the one left in pick.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = n_req; off >= 1; off--) begin
            cand = int'(last_grant) + off;
            if (cand >= n_req) cand = cand - n_req;
            cand_idx = idx_w'(cand);
            if (bus.req_valid[cand_idx]) begin
                pick       = cand_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        last_nx   = last_grant;
        done_nx   = '0;
        result_nx = bus.result;
        in1_nx    = bus.mult_in1;
        in2_nx    = bus.mult_in2;
        en_nx     = bus.mult_enable;
        busy_nx   = bus.busy;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    in1_nx   = bus.req_in1[pick];
                    in2_nx   = bus.req_in2[pick];
                    grant_nx = pick;
                    last_nx  = pick;
                    en_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.mult_ready) begin
                    result_nx      = bus.mult_result;
                    done_nx[grant] = 1'b1;
                    en_nx          = 1'b0;
                    state_nx       = CLEAR;
                end
            end
            CLEAR: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                en_nx    = 1'b0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= idx_w'(n_req - 1);
            bus.req_done    <= '0;
            bus.result      <= '0;
            bus.busy        <= 1'b0;
            bus.mult_enable <= 1'b0;
            bus.mult_in1    <= '0;
            bus.mult_in2    <= '0;
        end else begin
            state           <= state_nx;
            grant           <= grant_nx;
            last_grant      <= last_nx;
            bus.req_done    <= done_nx;
            bus.result      <= result_nx;
            bus.busy        <= busy_nx;
            bus.mult_enable <= en_nx;
            bus.mult_in1    <= in1_nx;
            bus.mult_in2    <= in2_nx;
        end
    end
endmodule

// File: tb/tb_reflet_float_mult_arbiter.sv
// Directed bench for the float multiplier arbiter with a table-driven
// multiplier model whose latency is set per test.
module tb_reflet_float_mult_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat     = 2;
    int   cnt     = 0;
    int   done_cnt = 0;

    reflet_float_mult_arbiter_if #(.n_req(2)) bus();

    reflet_float_mult_arbiter #(.n_req(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40A00000, 32'h41700000}: prod = 32'h42960000;
            {32'h41E00000, 32'hC1700000}: prod = 32'hC3D20000;
            {32'h00000000, 32'h42C80000}: prod = 32'h00000000;
            {32'h00000000, 32'h00000000}: prod = 32'h00000000;
            default:                      prod = 32'hDEADBEEF;
        endcase
    endfunction

    // Multiplier model: ready once 'lat' enabled cycles have elapsed.
    always @(posedge clk) begin
        if (!bus.mult_enable) cnt <= 0;
        else                  cnt <= cnt + 1;
    end
    assign bus.mult_ready  = bus.mult_enable && (cnt >= lat);
    assign bus.mult_result = prod(bus.mult_in1, bus.mult_in2);

    always @(posedge clk) begin
        if (|bus.req_done) done_cnt <= done_cnt + $countones(bus.req_done);
    end

    task automatic apply_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        lat = 2;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(output int idx, output logic [31:0] res, output int cyc);
        bit found;
        found = 1'b0;
        idx = -1;
        res = 32'h0;
        cyc = -1;
        for (int c = 1; c <= 100 && !found; c++) begin
            @(negedge clk);
            if (|bus.req_done) begin
                found = 1'b1;
                cyc = c;
                res = bus.result;
                for (int i = 0; i < 2; i++) if (bus.req_done[i]) idx = i;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        @(negedge clk);
        n_tests++; if (bus.req_done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", bus.req_done); end
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.mult_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", bus.mult_enable); end
        n_tests++; if (bus.mult_in1 !== 32'h0) begin n_fail++; $display("FAIL reset_in1: got %h want 0", bus.mult_in1); end
        n_tests++; if (bus.mult_in2 !== 32'h0) begin n_fail++; $display("FAIL reset_in2: got %h want 0", bus.mult_in2); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int idx, cyc, dc0;
        logic [31:0] res;
        apply_reset();
        lat = 3;
        dc0 = done_cnt;
        bus.req_in1[0] = 32'h40A00000;
        bus.req_in2[0] = 32'h41700000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b1 || bus.mult_enable !== 1'b1) begin n_fail++; $display("FAIL single_run: got busy=%b en=%b want 1 1", bus.busy, bus.mult_enable); end
        n_tests++; if (bus.mult_in1 !== 32'h40A00000 || bus.mult_in2 !== 32'h41700000) begin n_fail++; $display("FAIL single_ops: got %h %h want 40a00000 41700000", bus.mult_in1, bus.mult_in2); end
        wait_done(idx, res, cyc);
        n_tests++; if (idx !== 0) begin n_fail++; $display("FAIL single_idx: got %0d want 0", idx); end
        n_tests++; if (res !== 32'h42960000) begin n_fail++; $display("FAIL single_result: got %h want 42960000", res); end
        n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", cyc); end
        n_tests++; if (bus.mult_enable !== 1'b0) begin n_fail++; $display("FAIL single_clear_en: got %b want 0", bus.mult_enable); end
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_tests++; if (bus.req_done !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got done=%b busy=%b want 00 0", bus.req_done, bus.busy); end
        repeat (4) @(negedge clk);
        n_tests++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL single_once: got %0d pulses want 1", done_cnt - dc0); end
    endtask

    task automatic test_contention();
        int idx, cyc;
        logic [31:0] res;
        apply_reset();
        bus.req_in1[0] = 32'h41E00000; bus.req_in2[0] = 32'hC1700000;
        bus.req_in1[1] = 32'h40A00000; bus.req_in2[1] = 32'h41700000;
        bus.req_valid = 2'b11;
        wait_done(idx, res, cyc);
        n_tests++; if (idx !== 0) begin n_fail++; $display("FAIL cont_first_idx: got %0d want 0", idx); end
        n_tests++; if (res !== 32'hC3D20000) begin n_fail++; $display("FAIL cont_first_result: got %h want c3d20000", res); end
        bus.req_valid[0] = 1'b0;
        wait_done(idx, res, cyc);
        n_tests++; if (idx !== 1) begin n_fail++; $display("FAIL cont_second_idx: got %0d want 1", idx); end
        n_tests++; if (res !== 32'h42960000) begin n_fail++; $display("FAIL cont_second_result: got %h want 42960000", res); end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_fairness();
        int idx, cyc;
        logic [31:0] res;
        int exp_idx [4] = '{0, 1, 0, 1};
        apply_reset();
        lat = 1;
        bus.req_in1[0] = 32'h41E00000; bus.req_in2[0] = 32'hC1700000;
        bus.req_in1[1] = 32'h40A00000; bus.req_in2[1] = 32'h41700000;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(idx, res, cyc);
            n_tests++; if (idx !== exp_idx[k]) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", k, idx, exp_idx[k]); end
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_operand_change();
        int idx, cyc;
        logic [31:0] res;
        apply_reset();
        lat = 4;
        bus.req_in1[0] = 32'h40A00000; bus.req_in2[0] = 32'h41700000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_in1[0] = 32'h0; bus.req_in2[0] = 32'h0;
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_tests++; if (bus.mult_in1 !== 32'h40A00000 || bus.mult_in2 !== 32'h41700000) begin n_fail++; $display("FAIL opchg_held: got %h %h want 40a00000 41700000", bus.mult_in1, bus.mult_in2); end
        wait_done(idx, res, cyc);
        n_tests++; if (idx !== 0) begin n_fail++; $display("FAIL opchg_idx: got %0d want 0", idx); end
        n_tests++; if (res !== 32'h42960000) begin n_fail++; $display("FAIL opchg_result: got %h want 42960000", res); end
    endtask

    task automatic test_reset_mid_run();
        int idx, cyc, dc0;
        logic [31:0] res;
        apply_reset();
        bus.req_in1[0] = 32'h40A00000; bus.req_in2[0] = 32'h41700000;
        bus.req_in1[1] = 32'h41E00000; bus.req_in2[1] = 32'hC1700000;
        bus.req_valid = 2'b01;
        wait_done(idx, res, cyc);
        bus.req_valid = 2'b00;
        lat = 6;
        @(negedge clk);
        bus.req_valid = 2'b10;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", bus.busy); end
        dc0 = done_cnt;
        reset = 1'b0;
        #1;
        n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
        n_tests++; if (bus.busy !== 1'b0 || bus.mult_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got busy=%b en=%b want 0 0", bus.busy, bus.mult_enable); end
        n_tests++; if (bus.mult_in1 !== 32'h0 || bus.mult_in2 !== 32'h0) begin n_fail++; $display("FAIL rstmid_ops: got %h %h want 0 0", bus.mult_in1, bus.mult_in2); end
        n_tests++; if (bus.req_done !== 2'b00) begin n_fail++; $display("FAIL rstmid_done: got %b want 00", bus.req_done); end
        bus.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        n_tests++; if (done_cnt !== dc0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - dc0); end
        reset = 1'b1;
        lat = 2;
        wait_done(idx, res, cyc);
        n_tests++; if (idx !== 0) begin n_fail++; $display("FAIL rstmid_prio: got %0d want 0", idx); end
        n_tests++; if (res !== 32'h42960000) begin n_fail++; $display("FAIL rstmid_after_result: got %h want 42960000", res); end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_zero_operand();
        int idx, cyc, dc0;
        logic [31:0] res;
        apply_reset();
        lat = 0;
        dc0 = done_cnt;
        bus.req_in1[1] = 32'h00000000; bus.req_in2[1] = 32'h42C80000;
        bus.req_valid = 2'b10;
        wait_done(idx, res, cyc);
        bus.req_valid = 2'b00;
        n_tests++; if (idx !== 1) begin n_fail++; $display("FAIL zero_idx: got %0d want 1", idx); end
        n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL zero_result: got %h want 0", res); end
        n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", cyc); end
        repeat (4) @(negedge clk);
        n_tests++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL zero_once: got %0d pulses want 1", done_cnt - dc0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_operand_change();
        test_reset_mid_run();
        test_zero_operand();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reflet_float_mult_arbiter.md
# reflet_float_mult_arbiter

Round-robin arbiter and sequencer that shares one `reflet_float_mult` between `n_req` requesters. It latches the granted requester's operands and drives the multiplier's `enable` until `ready` is seen. It then returns the product with a one-cycle done pulse to that requester, and clears the multiplier before the next grant. It sits between the FPU front-end ports and the single multiplier instance.

## Interface
- `n_req`, default 2: number of requesters, legal range 2..8.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  n_req  bit i high means requester i wants a product.
- `req_in1`  in  32*n_req  operand 1 of requester i, in bits [32i+31:32i].
- `req_in2`  in  32*n_req  operand 2 of requester i, same packing.
- `req_done`  out  n_req  one-cycle pulse on bit i when requester i's product is on `result`.
- `result`  out  32  last product; holds until the next completion.
- `busy`  out  1  high while a grant is active (states RUN and CLEAR).
- `mult_enable`  out  1  drives multiplier `enable`.
- `mult_in1`, `mult_in2`  out  32 each  drive multiplier `in1`/`in2`; held stable throughout RUN.
- `mult_ready`  in  1  multiplier `ready`.
- `mult_result`  in  32  multiplier `mult`.

## Operation
- Reset values:
  - State IDLE.
  - `req_done`=0, `result`=0, `busy`=0, `mult_enable`=0, `mult_in1`=0, `mult_in2`=0.
  - `last_grant`=n_req-1, so requester 0 has first priority after reset.
- State IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise grant the first set bit searching upward, wrapping around, starting at `last_grant`+1 mod n_req.
  - On a grant: latch that requester's operands into `mult_in1`/`mult_in2`, set `grant` and `last_grant` to its index, go to RUN.
- State RUN:
  - `mult_enable`=1.
  - When `mult_ready`=1: latch `mult_result` into `result`, pulse `req_done[grant]`, go to CLEAR.
- State CLEAR:
  - `mult_enable`=0 for exactly one cycle so the multiplier restarts.
  - Go to IDLE.
- Requester protocol:
  - Hold `req_valid` high and operands stable until `req_done`.
  - Drop `req_valid` in the cycle after `req_done`, or keep it high to issue another request.
- Changing operands or dropping `req_valid` during RUN has no effect: the latched operation completes and `req_done` still pulses.
- A requester that keeps `req_valid` high after its done is served again only after every other pending requester (round-robin fairness).
- At most one `req_done` bit is high in any cycle; `result` is valid in the same cycle as the pulse.
- If `mult_ready` is already high in the first RUN cycle, the operation completes there; there is no minimum RUN length.
- Reset asserted mid-operation: all state returns to reset values immediately, the in-flight product is discarded, and no `req_done` is issued.

## Timing
- Cycle 0: IDLE sees `req_valid`; operands are latched at the edge ending cycle 0.
- Cycle 1: RUN; `mult_enable`=1 and `busy`=1.
- Cycle k: first RUN cycle with `mult_ready`=1; `result` and `req_done` are registered at the edge ending cycle k and visible in cycle k+1.
- Cycle k+1: CLEAR, with `mult_enable`=0.
- Cycle k+2: IDLE; a new grant can be latched in this cycle.
- Back-to-back throughput is one product per (multiplier latency + 3) cycles.
- Requests arriving during RUN or CLEAR wait; no request is lost.
- The arbiter adds no combinational path from `req_*` inputs to `mult_*` outputs; all outputs are registered.

## Test plan
- Single request:
  - Stimulus: req 0 with 0x40A00000 × 0x41700000 (5.0 × 15.0).
  - Required: `req_done[0]` pulses exactly once, `result`=0x42960000 (75.0), `mult_enable` is low for one cycle afterwards.
- Contention:
  - Stimulus: req 0 and req 1 both raised in the same cycle; req 0 = 28.0 × −15.0 (0x41E00000 × 0xC1700000), req 1 = 5.0 × 15.0.
  - Required: req 0 served first with `result`=0xC3D20000 (−420.0), then req 1 with 0x42960000.
- Fairness:
  - Stimulus: req 0 and req 1 held valid continuously.
  - Required: grants alternate 0,1,0,1 over 4 completions, with no requester served twice in a row.
- Operand change during RUN:
  - Stimulus: req 0 operands changed to 0×0 while in RUN.
  - Required: `result` still equals the originally latched product.
- Reset mid-RUN:
  - Stimulus: `reset` pulsed low during RUN.
  - Required: all outputs return to 0 at once and no `req_done` is issued.
  - Then: the next request is served from req 0 priority.
- Zero operand:
  - Stimulus: 0x00000000 × 0x42C80000 (0 × 100.0).
  - Required: `result`=0x00000000 and `req_done` pulses once.
